// File: rtl/prbs_ber_checker_pkg.sv
// Shared PRBS definitions: tap positions per order, checker FSM states and
// helpers for picking taps and validating the polynomial order.
package prbs_ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int TAP_A_7  = 7;
  localparam int TAP_B_7  = 6;
  localparam int TAP_A_9  = 9;
  localparam int TAP_B_9  = 5;
  localparam int TAP_A_15 = 15;
  localparam int TAP_B_15 = 14;
  localparam int TAP_A_23 = 23;
  localparam int TAP_B_23 = 18;
  localparam int TAP_A_31 = 31;
  localparam int TAP_B_31 = 28;

  function automatic bit prbs_len_legal(input int len);
    return (len == 7) || (len == 9) || (len == 15) || (len == 23) || (len == 31);
  endfunction

  // second=0 selects TAP_A, second=1 selects TAP_B (1-based bit positions).
  function automatic int prbs_tap(input int len, input bit second);
    int t;
    case (len)
      7:       t = second ? TAP_B_7  : TAP_A_7;
      9:       t = second ? TAP_B_9  : TAP_A_9;
      15:      t = second ? TAP_B_15 : TAP_A_15;
      23:      t = second ? TAP_B_23 : TAP_A_23;
      31:      t = second ? TAP_B_31 : TAP_A_31;
      default: t = second ? len - 1 : len;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prbs_ber_checker_if.sv
// Bit-stream input and status/counter readout of the PRBS BER checker.
interface prbs_ber_checker_if #(
  parameter int NB_COUNT = 32
);
  logic                i_enable;
  logic                i_bit;
  logic                i_clear;
  logic                o_lock;
  logic                o_err_pulse;
  logic [NB_COUNT-1:0] o_bit_count;
  logic [NB_COUNT-1:0] o_err_count;
  logic                o_overflow;

  modport master (
    output i_enable, i_bit, i_clear,
    input  o_lock, o_err_pulse, o_bit_count, o_err_count, o_overflow
  );

  modport slave (
    input  i_enable, i_bit, i_clear,
    output o_lock, o_err_pulse, o_bit_count, o_err_count, o_overflow
  );
endinterface

// File: rtl/prbs_ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag that is set
// once the count reaches all-ones.
module prbs_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Clear takes priority over an increment arriving on the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      sat_d = sat_q | (cnt_d == '1);
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign count_o = cnt_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/prbs_ber_checker.sv
// Receive-side PRBS checker: self-synchronises to the incoming stream, tracks
// lock with a SEARCH/VERIFY/LOCKED FSM and counts bits and errors while locked.
module prbs_ber_checker
  import prbs_ber_checker_pkg::*;
#(
  parameter int PRBS_LEN       = 9,
  parameter int NB_COUNT       = 32,
  parameter int LOCK_THRESHOLD = 16,
  parameter int WINDOW         = 64,
  parameter int UNLOCK_ERRORS  = 8
) (
  input  logic                   clock,
  input  logic                   i_reset,
  prbs_ber_checker_if.slave      bus
);

  if (!prbs_len_legal(PRBS_LEN)) begin : g_bad_len
    $error("prbs_ber_checker: PRBS_LEN must be one of 7, 9, 15, 23, 31");
  end

  localparam int TAP_A = prbs_tap(PRBS_LEN, 1'b0);
  localparam int TAP_B = prbs_tap(PRBS_LEN, 1'b1);
  localparam int LW    = $clog2(PRBS_LEN + 1);
  localparam int MW    = $clog2(LOCK_THRESHOLD + 1);
  localparam int WW    = $clog2(WINDOW + 1);
  localparam int EW    = $clog2(UNLOCK_ERRORS + 1);

  localparam logic [LW-1:0] LOAD_LAST  = LW'(PRBS_LEN - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_THRESHOLD - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERRORS - 1);

  state_e              state_q;
  logic [PRBS_LEN-1:0] sr_q;
  logic [LW-1:0]       load_cnt_q;
  logic [MW-1:0]       match_cnt_q;
  logic [WW-1:0]       win_cnt_q;
  logic [EW-1:0]       win_err_q;
  logic                lock_q;
  logic                err_pulse_q;

  logic pred;
  logic mismatch;
  logic sr_zero;
  logic count_en;
  logic err_en;

  assign pred     = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
  assign mismatch = bus.i_bit ^ pred;
  assign sr_zero  = (sr_q == '0);
  assign count_en = bus.i_enable && (state_q == ST_LOCKED);
  assign err_en   = count_en && mismatch;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_SEARCH;
      sr_q        <= '0;
      load_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= err_en;
      if (bus.i_enable) begin
        unique case (state_q)
          ST_SEARCH: begin
            sr_q <= {sr_q[PRBS_LEN-2:0], bus.i_bit};
            if (load_cnt_q == LOAD_LAST) begin
              state_q     <= ST_VERIFY;
              load_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + LW'(1);
            end
          end
          ST_VERIFY: begin
            sr_q <= {sr_q[PRBS_LEN-2:0], bus.i_bit};
            // An all-zero register predicts zeros forever, so it is never trusted.
            if (mismatch || sr_zero) begin
              state_q    <= ST_SEARCH;
              load_cnt_q <= '0;
            end else if (match_cnt_q == MATCH_LAST) begin
              state_q   <= ST_LOCKED;
              lock_q    <= 1'b1;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MW'(1);
            end
          end
          ST_LOCKED: begin
            // Free-running on the prediction so a received error is not fed back.
            sr_q <= {sr_q[PRBS_LEN-2:0], pred};
            if (mismatch && (win_err_q == ERR_LAST)) begin
              state_q    <= ST_SEARCH;
              lock_q     <= 1'b0;
              load_cnt_q <= '0;
              win_cnt_q  <= '0;
              win_err_q  <= '0;
            end else if (win_cnt_q == WIN_LAST) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WW'(1);
              win_err_q <= win_err_q + EW'(mismatch);
            end
          end
          default: begin
            state_q    <= ST_SEARCH;
            lock_q     <= 1'b0;
            load_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  logic [NB_COUNT-1:0] bit_count;
  logic [NB_COUNT-1:0] err_count;
  logic                bit_sat;
  logic                err_sat;

  prbs_sat_counter #(
    .WIDTH (NB_COUNT)
  ) u_bit_counter (
    .clock   (clock),
    .i_reset (i_reset),
    .inc_i   (count_en),
    .clr_i   (bus.i_clear),
    .count_o (bit_count),
    .sat_o   (bit_sat)
  );

  prbs_sat_counter #(
    .WIDTH (NB_COUNT)
  ) u_err_counter (
    .clock   (clock),
    .i_reset (i_reset),
    .inc_i   (err_en),
    .clr_i   (bus.i_clear),
    .count_o (err_count),
    .sat_o   (err_sat)
  );

  // Errors never outnumber bits, so err_sat implies bit_sat; OR-ing is harmless.
  assign bus.o_lock      = lock_q;
  assign bus.o_err_pulse = err_pulse_q;
  assign bus.o_bit_count = bit_count;
  assign bus.o_err_count = err_count;
  assign bus.o_overflow  = bit_sat | err_sat;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Scoreboard bench: PRBS9/32-bit-counter checker and PRBS15/4-bit-counter
// checker driven with directed streams; a monitor compares at checkpoints.
module tb_prbs_ber_checker;

  logic clock;
  logic rst9;
  logic rst15;

  prbs_ber_checker_if #(.NB_COUNT(32)) if9  ();
  prbs_ber_checker_if #(.NB_COUNT(4))  if15 ();

  prbs_ber_checker #(
    .PRBS_LEN(9), .NB_COUNT(32), .LOCK_THRESHOLD(16), .WINDOW(64), .UNLOCK_ERRORS(8)
  ) dut9 (
    .clock   (clock),
    .i_reset (rst9),
    .bus     (if9)
  );

  prbs_ber_checker #(
    .PRBS_LEN(15), .NB_COUNT(4), .LOCK_THRESHOLD(16), .WINDOW(64), .UNLOCK_ERRORS(8)
  ) dut15 (
    .clock   (clock),
    .i_reset (rst15),
    .bus     (if15)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          dut;    // 0: PRBS9 checker, 1: PRBS15 checker
    int          idx;    // enabled-bit number after which to compare
    logic        lock;
    logic        pulse;
    logic [31:0] bc;
    logic [31:0] ec;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n9    = 0;
  int   n15   = 0;

  logic [8:0]  g9  = 9'h1FF;
  logic [14:0] g15 = 15'h7FFF;

  // Enabled bits seen by each DUT since its last reset.
  always @(posedge clock or negedge rst9) begin
    if (!rst9) n9 <= 0;
    else if (if9.i_enable) n9 <= n9 + 1;
  end

  always @(posedge clock or negedge rst15) begin
    if (!rst15) n15 <= 0;
    else if (if15.i_enable) n15 <= n15 + 1;
  end

  task automatic push(input bit d, input int idx, input logic l, input logic p,
                      input int bc, input int ec, input logic ovf);
    exp_t e;
    e.dut = d; e.idx = idx; e.lock = l; e.pulse = p;
    e.bc = bc; e.ec = ec; e.ovf = ovf;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s after bit %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_entry(input exp_t e);
    logic        a_lock, a_pulse, a_ovf;
    logic [31:0] a_bc, a_ec;
    string       tag;
    if (e.dut) begin
      tag = "dut15"; a_lock = if15.o_lock; a_pulse = if15.o_err_pulse;
      a_bc = {28'd0, if15.o_bit_count}; a_ec = {28'd0, if15.o_err_count};
      a_ovf = if15.o_overflow;
    end else begin
      tag = "dut9"; a_lock = if9.o_lock; a_pulse = if9.o_err_pulse;
      a_bc = if9.o_bit_count; a_ec = if9.o_err_count; a_ovf = if9.o_overflow;
    end
    $display("[%s] bit %0d: lock=%0b pulse=%0b bits=%0d errs=%0d ovf=%0b", tag, e.idx,
             a_lock, a_pulse, a_bc, a_ec, a_ovf);
    chk({tag, ".lock"},  e.idx, {31'd0, a_lock},  {31'd0, e.lock});
    chk({tag, ".pulse"}, e.idx, {31'd0, a_pulse}, {31'd0, e.pulse});
    chk({tag, ".bits"},  e.idx, a_bc, e.bc);
    chk({tag, ".errs"},  e.idx, a_ec, e.ec);
    chk({tag, ".ovf"},   e.idx, {31'd0, a_ovf},   {31'd0, e.ovf});
  endtask

  // Monitor: pops every expectation whose bit number has been reached.
  initial begin
    exp_t e;
    int   n;
    bit   done;
    forever begin
      @(negedge clock);
      done = 1'b0;
      while (!done && (q.size() > 0)) begin
        e = q[0];
        n = e.dut ? n15 : n9;
        if (e.idx > n) begin
          done = 1'b1;
        end else begin
          e = q.pop_front();
          if (e.idx < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL checkpoint dut%0d bit %0d: reached bit %0d, expected bit %0d",
                     e.dut ? 15 : 9, e.idx, n, e.idx);
          end else begin
            check_entry(e);
          end
        end
      end
    end
  end

  task automatic gen9(output logic b);
    b  = g9[8] ^ g9[4];
    g9 = {g9[7:0], b};
  endtask

  task automatic gen15(output logic b);
    b   = g15[14] ^ g15[13];
    g15 = {g15[13:0], b};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      if9.i_enable = 1'b0;  if9.i_clear = 1'b0;
      if15.i_enable = 1'b0; if15.i_clear = 1'b0;
    end
  endtask

  task automatic send9(input logic b, input logic clr);
    @(posedge clock); #1;
    if9.i_enable = 1'b1; if9.i_bit = b; if9.i_clear = clr;
  endtask

  // One enabled bit every fourth clock.
  task automatic send15(input logic b, input logic clr);
    repeat (3) begin
      @(posedge clock); #1;
      if15.i_enable = 1'b0; if15.i_clear = 1'b0;
    end
    @(posedge clock); #1;
    if15.i_enable = 1'b1; if15.i_bit = b; if15.i_clear = clr;
  endtask

  initial begin
    logic b;
    logic inv;
    rst9 = 1'b0; rst15 = 1'b0;
    if9.i_enable = 1'b0;  if9.i_bit = 1'b0;  if9.i_clear = 1'b0;
    if15.i_enable = 1'b0; if15.i_bit = 1'b0; if15.i_clear = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0, 0);
    #100;
    rst9 = 1'b1; rst15 = 1'b1;

    // PRBS9: lock, clean count, single error, clear, window unlock, relock.
    for (int i = 1; i <= 1160; i++) begin
      gen9(b);
      inv = (i == 1030) || ((i >= 1120) && (i <= 1134) && (i % 2 == 0));
      send9(b ^ inv, i == 1110);
      case (i)
        24:   push(0, i, 0, 0, 0,    0, 0);
        25:   push(0, i, 1, 0, 0,    0, 0);
        26:   push(0, i, 1, 0, 1,    0, 0);
        525:  push(0, i, 1, 0, 500,  0, 0);
        1025: push(0, i, 1, 0, 1000, 0, 0);
        1029: push(0, i, 1, 0, 1004, 0, 0);
        1030: push(0, i, 1, 1, 1005, 1, 0);
        1031: push(0, i, 1, 0, 1006, 1, 0);
        1100: push(0, i, 1, 0, 1075, 1, 0);
        1110: push(0, i, 1, 0, 0,    0, 0);
        1120: push(0, i, 1, 1, 10,   1, 0);
        1126: push(0, i, 1, 1, 16,   4, 0);
        1133: push(0, i, 1, 0, 23,   7, 0);
        1134: push(0, i, 0, 1, 24,   8, 0);
        1135: push(0, i, 0, 0, 24,   8, 0);
        1158: push(0, i, 0, 0, 24,   8, 0);
        1159: push(0, i, 1, 0, 24,   8, 0);
        1160: push(0, i, 1, 0, 25,   8, 0);
        default: ;
      endcase
    end
    idle(3);

    // PRBS9 after reset with constant-zero input: must never lock.
    rst9 = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    rst9 = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      send9(1'b0, 1'b0);
      if ((i == 25) || (i % 100 == 0)) push(0, i, 0, 0, 0, 0, 0);
    end
    idle(3);

    // PRBS15, 4-bit counters, one enable in four: saturation, clear, error.
    for (int i = 1; i <= 60; i++) begin
      gen15(b);
      send15(b ^ (i == 53), i == 51);
      case (i)
        30: push(1, i, 0, 0, 0,  0, 0);
        31: push(1, i, 1, 0, 0,  0, 0);
        45: push(1, i, 1, 0, 14, 0, 0);
        46: push(1, i, 1, 0, 15, 0, 1);
        50: push(1, i, 1, 0, 15, 0, 1);
        51: push(1, i, 1, 0, 0,  0, 0);
        52: push(1, i, 1, 0, 1,  0, 0);
        53: push(1, i, 1, 1, 2,  1, 0);
        54: push(1, i, 1, 0, 3,  1, 0);
        60: push(1, i, 1, 0, 9,  1, 0);
        default: ;
      endcase
    end
    idle(3);

    // Reset mid-lock: outputs clear while reset is held, then reacquire.
    rst15 = 1'b0;
    push(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    rst15 = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      gen15(b);
      send15(b, 1'b0);
      case (i)
        30: push(1, i, 0, 0, 0, 0, 0);
        31: push(1, i, 1, 0, 0, 0, 0);
        35: push(1, i, 1, 0, 4, 0, 0);
        default: ;
      endcase
    end
    idle(6);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL checkpoint dut%0d bit %0d: never reached, expected bit %0d",
               e.dut ? 15 : 9, e.idx, e.idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
